scaler_coe_table: RTL

- Coefficient responder on the scaler's coefficient port: answers `coe_adr`/`coe_adr_en` reads with a packed `COE_COUNT`-tap coefficient word.
- Holds two banks of `SCALE_STEP/COE_COUNT` entries: one active (read by the scaler), one shadow (loaded serially by host/CPU logic).
- The banks swap only at a frame boundary, so a table update never tears mid-frame.
- Includes a post-reset clear sequencer, because RAM contents cannot be reset.

---
 rtl/scaler_coe_table_if.sv | 29 ++
 rtl/scaler_coe_table.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/scaler_coe_table_if.sv
// Coefficient port bundle: scaler read side, host serial-load side and status.
// Signal names follow the block's port list; widths come from the table geometry.
interface scaler_coe_table_if #(
  parameter int unsigned ADR_W     = 10,
  parameter int unsigned COE_WIDTH = 10,
  parameter int unsigned COE_COUNT = 4
);
  logic                           coe_adr_en;
  logic [ADR_W-1:0]               coe_adr;
  logic [COE_WIDTH*COE_COUNT-1:0] coe_o;
  logic                           vs_i;
  logic                           wr_start;
  logic                           wr_en;
  logic [COE_WIDTH-1:0]           wr_data;
  logic                           init_busy;
  logic                           load_done;
  logic                           bank_sel;
  logic                           wr_err;

  modport master (
    output coe_adr_en, coe_adr, vs_i, wr_start, wr_en, wr_data,
    input  coe_o, init_busy, load_done, bank_sel, wr_err
  );

  modport slave (
    input  coe_adr_en, coe_adr, vs_i, wr_start, wr_en, wr_data,
    output coe_o, init_busy, load_done, bank_sel, wr_err
  );
endinterface

// File: rtl/scaler_coe_table.sv
// Double-banked coefficient table: the scaler reads the active bank while the host
// loads the shadow bank serially; banks swap on a vsync rising edge once loading is done.
module scaler_coe_table #(
  parameter string       VENDOR_RAM_STYLE = "MLAB",
  parameter int unsigned SCALE_STEP       = 4096,
  parameter int unsigned COE_WIDTH        = 10,
  parameter int unsigned COE_COUNT        = 4
) (
  input logic               clk,
  input logic               rst,
  scaler_coe_table_if.slave coe_if
);
  localparam int unsigned DEPTH  = SCALE_STEP / COE_COUNT;
  localparam int unsigned ADR_W  = $clog2(DEPTH);
  localparam int unsigned TAP_W  = (COE_COUNT > 1) ? $clog2(COE_COUNT) : 1;
  localparam int unsigned WORD_W = COE_WIDTH * COE_COUNT;
  localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(DEPTH - 1);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(COE_COUNT - 1);

  typedef enum logic [1:0] {StInit, StIdle, StLoad, StPend} state_e;

  (* ramstyle = VENDOR_RAM_STYLE *) logic [WORD_W-1:0] r_bank0 [DEPTH];
  (* ramstyle = VENDOR_RAM_STYLE *) logic [WORD_W-1:0] r_bank1 [DEPTH];

  state_e               r_state;
  logic [ADR_W-1:0]     r_clr_cnt;
  logic [ADR_W-1:0]     r_adr_cnt;
  logic [TAP_W-1:0]     r_tap_cnt;
  logic [COE_WIDTH-1:0] r_asm [COE_COUNT];
  logic                 r_vs_q;
  logic [WORD_W-1:0]    r_coe;
  logic                 r_init_busy;
  logic                 r_load_done;
  logic                 r_bank_sel;
  logic                 r_wr_err;

  logic                 w_vs_rise;
  logic                 w_clr;
  logic                 w_restart;
  logic                 w_accept;
  logic [TAP_W-1:0]     w_tap;
  logic [ADR_W-1:0]     w_adr;
  logic                 w_last_tap;
  logic                 w_last_word;
  logic [WORD_W-1:0]    w_word;
  logic [WORD_W-1:0]    w_rd_word;

  assign w_vs_rise   = coe_if.vs_i & ~r_vs_q;
  assign w_clr       = (r_state == StInit);
  assign w_restart   = coe_if.wr_start & (r_state != StInit);
  assign w_accept    = coe_if.wr_en & ((r_state == StLoad) | w_restart);
  // A restart with a simultaneous write uses that write as tap 0 of address 0.
  assign w_tap       = w_restart ? '0 : r_tap_cnt;
  assign w_adr       = w_restart ? '0 : r_adr_cnt;
  assign w_last_tap  = w_accept & (w_tap == LAST_TAP);
  assign w_last_word = w_last_tap & (w_adr == LAST_ADR);
  assign w_rd_word   = r_bank_sel ? r_bank1[coe_if.coe_adr] : r_bank0[coe_if.coe_adr];

  always_comb begin
    w_word = '0;
    for (int k = 0; k < COE_COUNT; k++) begin
      w_word[k*COE_WIDTH +: COE_WIDTH] = (w_tap == TAP_W'(k)) ? coe_if.wr_data : r_asm[k];
    end
  end

  // RAM arrays carry no reset; the clear sequencer zeroes them after every reset.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_bank0[r_clr_cnt] <= '0;
      r_bank1[r_clr_cnt] <= '0;
    end else if (w_last_tap) begin
      if (r_bank_sel) begin
        r_bank0[w_adr] <= w_word;
      end else begin
        r_bank1[w_adr] <= w_word;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StInit;
      r_clr_cnt   <= '0;
      r_adr_cnt   <= '0;
      r_tap_cnt   <= '0;
      r_asm       <= '{default: '0};
      r_vs_q      <= 1'b0;
      r_coe       <= '0;
      r_init_busy <= 1'b1;
      r_load_done <= 1'b0;
      r_bank_sel  <= 1'b0;
      r_wr_err    <= 1'b0;
    end else begin
      r_vs_q   <= coe_if.vs_i;
      r_wr_err <= (coe_if.wr_en & ~w_accept) | (w_clr & coe_if.wr_start);

      if (w_clr) begin
        r_coe <= '0;
      end else if (coe_if.coe_adr_en) begin
        r_coe <= w_rd_word;
      end

      unique case (r_state)
        StInit: begin
          r_clr_cnt <= r_clr_cnt + ADR_W'(1);
          if (r_clr_cnt == LAST_ADR) begin
            r_state     <= StIdle;
            r_clr_cnt   <= '0;
            r_init_busy <= 1'b0;
          end
        end
        StIdle, StLoad, StPend: begin
          if (w_restart) begin
            r_state     <= StLoad;
            r_load_done <= 1'b0;
            r_tap_cnt   <= '0;
            r_adr_cnt   <= '0;
          end else if ((r_state == StPend) && w_vs_rise) begin
            r_state     <= StIdle;
            r_bank_sel  <= ~r_bank_sel;
            r_load_done <= 1'b0;
          end
          if (w_accept) begin
            r_asm[w_tap] <= coe_if.wr_data;
            if (w_last_tap) begin
              r_tap_cnt <= '0;
              if (w_last_word) begin
                r_state     <= StPend;
                r_load_done <= 1'b1;
                r_adr_cnt   <= '0;
              end else begin
                r_adr_cnt <= w_adr + ADR_W'(1);
              end
            end else begin
              r_tap_cnt <= w_tap + TAP_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign coe_if.coe_o     = r_coe;
  assign coe_if.init_busy = r_init_busy;
  assign coe_if.load_done = r_load_done;
  assign coe_if.bank_sel  = r_bank_sel;
  assign coe_if.wr_err    = r_wr_err;
endmodule
